// File: rtl/lane_seg_top_mul_requant_pipe.sv
// Pipelined signed multiplier with round/shift/saturate requantisation.
// The valid/ready pipeline collapses bubbles, so it sustains one product per cycle when not stalled.
module lane_seg_top_mul_requant_pipe #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 10,
    parameter int DOUT_WIDTH = 16,
    parameter int NUM_STAGE  = 3,
    parameter int SHIFT      = 8,
    parameter int ROUND      = 1,
    parameter int SAT        = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [DOUT_WIDTH-1:0] dout,
    output logic                         ovf,
    output logic                         ovf_sticky,
    input  logic                         ovf_clr
);

    localparam int W         = DIN0_WIDTH + DIN1_WIDTH;
    localparam int FIRST_RES = (NUM_STAGE == 1) ? 0 : ((NUM_STAGE == 2) ? 1 : 2);
    localparam int NRES      = NUM_STAGE - FIRST_RES;
    localparam int RSH       = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [W:0] RND = (ROUND != 0 && SHIFT > 0) ? ((W+1)'(1) << RSH) : '0;

    // Returns {ovf, dout}; overflow means Q does not fit the signed output range.
    function automatic logic [DOUT_WIDTH:0] requant(input logic signed [W-1:0] p);
        logic signed [W:0]     r;
        logic signed [W:0]     q;
        logic                  o;
        logic [DOUT_WIDTH-1:0] d;
        r = (W+1)'(p) + RND;
        q = r >>> SHIFT;
        o = (q != (W+1)'(signed'(q[DOUT_WIDTH-1:0])));
        if (o && SAT != 0)
            d = q[W] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}} : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        else
            d = q[DOUT_WIDTH-1:0];
        return {o, d};
    endfunction

    logic [NUM_STAGE-1:0] v;
    logic [NUM_STAGE-1:0] adv;
    logic [NUM_STAGE-1:0] ld;
    logic [NUM_STAGE:0]   vchain;

    assign vchain = {v, in_valid};
    assign ld     = adv & vchain[NUM_STAGE-1:0];

    always_comb begin
        adv = '0;
        adv[NUM_STAGE-1] = !v[NUM_STAGE-1] | out_ready;
        for (int unsigned i = 1; i < NUM_STAGE; i++)
            adv[NUM_STAGE-1-i] = !v[NUM_STAGE-1-i] | adv[NUM_STAGE-i];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_STAGE; k++)
                if (adv[k]) v[k] <= vchain[k];
        end
    end

    logic [DOUT_WIDTH:0] res_src;

    generate
        if (NUM_STAGE == 1) begin : g_s1
            logic signed [W-1:0] prod;
            assign prod    = din0 * din1;
            assign res_src = requant(prod);
        end else begin : g_sn
            logic signed [DIN0_WIDTH-1:0] a_q;
            logic signed [DIN1_WIDTH-1:0] b_q;
            logic signed [W-1:0]          prod;

            always_ff @(posedge ap_clk) begin
                if (ld[0]) begin
                    a_q <= din0;
                    b_q <= din1;
                end
            end

            assign prod = a_q * b_q;

            if (NUM_STAGE == 2) begin : g_s2
                assign res_src = requant(prod);
            end else begin : g_s3
                logic signed [W-1:0] p_q;
                always_ff @(posedge ap_clk) begin
                    if (ld[1]) p_q <= prod;
                end
                assign res_src = requant(p_q);
            end
        end
    endgenerate

    // Result slots (requant register plus retiming) are reset so dout reads 0 until real data lands.
    logic [DOUT_WIDTH:0] res    [NRES];
    logic [DOUT_WIDTH:0] res_in [NRES];

    always_comb begin
        res_in[0] = res_src;
        for (int unsigned j = 1; j < NRES; j++)
            res_in[j] = res[j-1];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int unsigned j = 0; j < NRES; j++)
                res[j] <= '0;
        end else begin
            for (int unsigned j = 0; j < NRES; j++)
                if (ld[FIRST_RES+j]) res[j] <= res_in[j];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[NUM_STAGE-1];
    assign dout      = res[NRES-1][DOUT_WIDTH-1:0];
    assign ovf       = res[NRES-1][DOUT_WIDTH];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            ovf_sticky <= 1'b0;
        else if (out_valid && out_ready && ovf)
            ovf_sticky <= 1'b1;
        else if (ovf_clr)
            ovf_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_lane_seg_top_mul_requant_pipe.sv
// Bench for lane_seg_top_mul_requant_pipe: three builds (default, 1-stage wrap, 5-stage floor)
// share one input stream; each has its own scoreboard, sticky model and occupancy check.
module tb_lane_seg_top_mul_requant_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic ovf_clr = 1'b0;
    logic signed [15:0] din0 = '0;
    logic signed [9:0]  din1 = '0;
    logic [2:0]  iready, ovalid, ovf, stk;
    logic [15:0] dout [3];

    always #5 clk = ~clk;

    lane_seg_top_mul_requant_pipe #(.NUM_STAGE(3)) u0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(iready[0]),
        .din0(din0), .din1(din1), .out_valid(ovalid[0]), .out_ready(out_ready),
        .dout(dout[0]), .ovf(ovf[0]), .ovf_sticky(stk[0]), .ovf_clr(ovf_clr));

    lane_seg_top_mul_requant_pipe #(.NUM_STAGE(1), .SAT(0)) u1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(iready[1]),
        .din0(din0), .din1(din1), .out_valid(ovalid[1]), .out_ready(out_ready),
        .dout(dout[1]), .ovf(ovf[1]), .ovf_sticky(stk[1]), .ovf_clr(ovf_clr));

    lane_seg_top_mul_requant_pipe #(.NUM_STAGE(5), .ROUND(0)) u2 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(iready[2]),
        .din0(din0), .din1(din1), .out_valid(ovalid[2]), .out_ready(out_ready),
        .dout(dout[2]), .ovf(ovf[2]), .ovf_sticky(stk[2]), .ovf_clr(ovf_clr));

    function automatic int ns(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 1 : 5);
    endfunction
    function automatic bit satp(input int i);
        return (i != 1);
    endfunction
    function automatic bit rndp(input int i);
        return (i != 2);
    endfunction

    // Reference: full-precision product, optional +128, >>>8, clamp or wrap to 16 bits.
    function automatic logic [16:0] model(input int a, input int b, input bit s, input bit r);
        longint p, q;
        logic o;
        logic [15:0] d;
        p = longint'(a) * longint'(b);
        if (r) p = p + 128;
        q = p >>> 8;
        o = (q > 32767) || (q < -32768);
        if (o && s) d = (q < 0) ? 16'h8000 : 16'h7fff;
        else d = q[15:0];
        return {o, d};
    endfunction

    typedef struct {
        logic [15:0] d;
        logic        o;
        int          c;
    } ent_t;

    typedef struct {
        int          a;
        int          b;
        logic [15:0] d;
        logic        o;
    } vec_t;

    ent_t sbq [3][$];
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit lat_on = 1'b0;
    bit tab_on = 1'b0;
    logic [15:0] tab_d = '0;
    logic tab_o = 1'b0;
    bit stk_m [3];
    bit hold_v [3];
    logic [15:0] hold_d [3];
    logic hold_o [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                chk("rst_out_valid", ovalid[i], 0);
                chk("rst_dout", dout[i], 0);
                chk("rst_sticky", stk[i], 0);
                sbq[i].delete();
                stk_m[i] = 1'b0;
                hold_v[i] = 1'b0;
            end else begin
                ent_t e;
                logic [16:0] m;
                bit dlv;
                chk("sticky", stk[i], stk_m[i]);
                chk("in_ready", iready[i], !(sbq[i].size() == ns(i) && !out_ready));
                if (hold_v[i]) begin
                    chk("hold_valid", ovalid[i], 1);
                    chk("hold_dout", dout[i], hold_d[i]);
                    chk("hold_ovf", ovf[i], hold_o[i]);
                end
                hold_v[i] = ovalid[i] && !out_ready;
                hold_d[i] = dout[i];
                hold_o[i] = ovf[i];
                if (in_valid && iready[i]) begin
                    m = model(int'(din0), int'(din1), satp(i), rndp(i));
                    e.d = (i == 0 && tab_on) ? tab_d : m[15:0];
                    e.o = (i == 0 && tab_on) ? tab_o : m[16];
                    e.c = cyc;
                    sbq[i].push_back(e);
                end
                dlv = 1'b0;
                if (ovalid[i] && out_ready) begin
                    if (sbq[i].size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_output: dut %0d dout %0d with empty scoreboard", i, dout[i]);
                    end else begin
                        e = sbq[i].pop_front();
                        chk("dout", dout[i], e.d);
                        chk("ovf", ovf[i], e.o);
                        if (lat_on) chk("latency", cyc - e.c, ns(i));
                        dlv = e.o;
                    end
                end
                if (dlv) stk_m[i] = 1'b1;
                else if (ovf_clr) stk_m[i] = 1'b0;
            end
        end
    end

    task automatic send(input int a, input int b, input bit t, input logic [15:0] d, input logic o);
        bit acc;
        din0 = 16'(a);
        din1 = 10'(b);
        tab_on = t;
        tab_d = d;
        tab_o = o;
        in_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            acc = iready[0];
            @(posedge clk);
            #1;
            if (acc) return;
        end
        checks++;
        $display("FAIL accept_timeout: in_ready stuck 0, expected 1 within 60 cycles");
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (sbq[0].size() + sbq[1].size() + sbq[2].size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_pending", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
    endtask

    vec_t tab [10];
    bit bp_on;

    initial begin
        tab[0] = '{100, 3, 16'd1, 1'b0};
        tab[1] = '{-100, 3, 16'hffff, 1'b0};
        tab[2] = '{128, 3, 16'd2, 1'b0};
        tab[3] = '{-128, 1, 16'd0, 1'b0};
        tab[4] = '{-32768, -512, 16'h7fff, 1'b1};
        tab[5] = '{32767, -512, 16'h8000, 1'b1};
        tab[6] = '{128, 1, 16'd1, 1'b0};
        tab[7] = '{-32768, 256, 16'h8000, 1'b0};
        tab[8] = '{-32768, -256, 16'h7fff, 1'b1};
        tab[9] = '{32767, 256, 16'h7fff, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        lat_on = 1'b1;

        for (int i = 0; i < 10; i++)
            send(tab[i].a, tab[i].b, 1'b1, tab[i].d, tab[i].o);
        in_valid = 1'b0;
        tab_on = 1'b0;
        drain();

        // Sticky: clear alone, then clear held across a delivered overflow.
        for (int i = 0; i < 3; i++) chk("sticky_after_sat", stk[i], 1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        for (int i = 0; i < 3; i++) chk("sticky_cleared", stk[i], 0);
        ovf_clr = 1'b1;
        send(-32768, -512, 1'b1, 16'h7fff, 1'b1);
        in_valid = 1'b0;
        tab_on = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("sticky_set_wins", stk[0], 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ovf_clr = 1'b0;
        drain();

        // Backpressure: out_ready 3 on / 2 off while streaming random pairs.
        lat_on = 1'b0;
        bp_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(int'($urandom_range(65535)) - 32768, int'($urandom_range(1023)) - 512,
                         1'b0, '0, 1'b0);
                in_valid = 1'b0;
                bp_on = 1'b0;
            end
            begin
                int k = 0;
                while (bp_on) begin
                    out_ready = (k % 5) < 3;
                    k++;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        lat_on = 1'b1;

        // Reset with data in flight, then a single post-reset transaction.
        for (int i = 0; i < 3; i++)
            send(int'($urandom_range(65535)) - 32768, int'($urandom_range(1023)) - 512,
                 1'b0, '0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send(2, 2, 1'b1, 16'd0, 1'b0);
        in_valid = 1'b0;
        tab_on = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
